// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// external ALU. One operation is in flight at a time. Operands are held
// in registers for the ALU, the result is captured after ALU_LAT cycles,
// and it is then presented to the winning requester until that requester
// takes it.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,       // active-low, asynchronous
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_opa,
    input  logic [15:0] req_opb,
    input  logic [5:0]  req_opcode,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [7:0]  alu_opa,
    output logic [7:0]  alu_opb,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  grant;
    logic        accept;
    logic        grant_idx;
    logic        rsp_hs;

    // Arbitration bookkeeping: last_q is the requester granted most
    // recently, g_q owns the transaction currently in flight.
    logic        last_q;
    logic        g_q;
    logic [2:0]  cnt_q;

    // Stage 0: operands latched at accept and held for the ALU.
    logic [7:0]  opa_p0;
    logic [7:0]  opb_p0;
    logic [2:0]  opcode_p0;

    // Stage 1: ALU result captured once the latency has elapsed.
    logic [7:0]  rsp_data_p1;

    // One-hot grant in IDLE; on a tie the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // reset is active-low, so the grant is visible only while running.
    assign req_ready  = reset ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign grant_idx  = req_ready[1];

    // The response is offered only to the owner; the other rsp_ready bit
    // is never looked at.
    assign rsp_valid  = (state == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_hs     = (state == RESP) && rsp_ready[g_q];

    assign busy       = (state != IDLE);
    assign alu_opa    = opa_p0;
    assign alu_opb    = opb_p0;
    assign alu_opcode = opcode_p0;
    assign rsp_data   = rsp_data_p1;

    // Next-state logic for the IDLE -> EXEC -> RESP transaction sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE (not straight to a new accept) keeps
                // one dead cycle between a handshake and the next grant.
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer, owner index and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;   // requester 0 wins the first tie
            g_q    <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            if (accept) begin
                last_q <= grant_idx;
                g_q    <= grant_idx;
                cnt_q  <= LAT_LOAD;
            end else if ((state == EXEC) && (cnt_q != 3'd0)) begin
                cnt_q  <= cnt_q - 3'd1;
            end
        end
    end

    // Operand registers: load the winner's fields on accept and hold them
    // until the next accept so the ALU sees stable inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_p0    <= 8'd0;
            opb_p0    <= 8'd0;
            opcode_p0 <= 3'd0;
        end else if (accept) begin
            opa_p0    <= grant_idx ? req_opa[15:8]    : req_opa[7:0];
            opb_p0    <= grant_idx ? req_opb[15:8]    : req_opb[7:0];
            opcode_p0 <= grant_idx ? req_opcode[5:3]  : req_opcode[2:0];
        end
    end

    // Result register: capture the ALU output unmodified at the end of
    // EXEC and hold it through RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data_p1 <= 8'd0;
        end else if ((state == EXEC) && (cnt_q == 3'd0)) begin
            rsp_data_p1 <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level timing model.
module tb_alu_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_opa = 16'h0;
    logic [15:0] req_opb = 16'h0;
    logic [5:0]  req_opcode = 6'h0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [7:0]  rsp_data;
    logic [7:0]  alu_opa;
    logic [7:0]  alu_opb;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_opcode (req_opcode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Bench ALU: 8-bit results, LAT clock cycles after operands appear.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        logic [15:0] w;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin w = {8'h00, a} * {8'h00, b}; return w[7:0]; end
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return a;
            default: return ~a;
        endcase
    endfunction

    logic [7:0] alu_pipe [LAT] = '{default: 8'h00};
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_opa, alu_opb, alu_opcode);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[LAT-1];

    // Transaction-level model: a transaction accepted in cycle c owns the
    // block until its handshake; the response appears at c+LAT+2.
    int         cyc = 0;
    bit         inflight;
    bit         g_m;
    bit         last_m;
    logic [7:0] mopa, mopb, res_m, data_m;
    logic [2:0] mop;
    int         rsp_start;

    logic [1:0] s_ready, s_rsp_valid;
    logic [7:0] s_rsp_data;
    logic       s_busy;

    function automatic logic [1:0] arb(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight = 1'b0;
        last_m   = 1'b1;
        g_m      = 1'b0;
        mopa     = 8'h00;
        mopb     = 8'h00;
        mop      = 3'h0;
        data_m   = 8'h00;
    endtask

    // One clock cycle: compare at negedge, advance model at posedge.
    task automatic cycle();
        logic [1:0] er, ev;
        @(negedge clk);
        er = (reset && !inflight) ? arb(req_valid, last_m) : 2'b00;
        ev = (inflight && cyc >= rsp_start) ? (g_m ? 2'b10 : 2'b01) : 2'b00;
        s_ready     = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_busy      = busy;
        chk("req_ready", 8'(s_ready), 8'(er));
        chk("rsp_valid", 8'(s_rsp_valid), 8'(ev));
        chk("busy", 8'(s_busy), 8'(inflight));
        chk("rsp_data", s_rsp_data, data_m);
        chk("alu_opa", alu_opa, mopa);
        chk("alu_opb", alu_opb, mopb);
        chk("alu_opcode", 8'(alu_opcode), 8'(mop));
        @(posedge clk);
        if (reset) begin
            if (er != 2'b00) begin
                inflight  = 1'b1;
                g_m       = er[1];
                last_m    = er[1];
                mopa      = g_m ? req_opa[15:8]   : req_opa[7:0];
                mopb      = g_m ? req_opb[15:8]   : req_opb[7:0];
                mop       = g_m ? req_opcode[5:3] : req_opcode[2:0];
                res_m     = alu_ref(mopa, mopb, mop);
                rsp_start = cyc + LAT + 2;
            end else if (ev != 2'b00 && rsp_ready[g_m]) begin
                inflight = 1'b0;
            end
        end
        cyc++;
        if (inflight && cyc == rsp_start) data_m = res_m;
        #1;
    endtask

    // Pull reset low, check outputs without waiting for a clock, hold two
    // cycles, then release just after a posedge.
    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        model_reset();
        chk("rst_req_ready", 8'(req_ready), 8'h00);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_alu_opa", alu_opa, 8'h00);
        chk("rst_alu_opb", alu_opb, 8'h00);
        chk("rst_alu_opcode", 8'(alu_opcode), 8'h00);
        cycle();
        cycle();
        reset     = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 60; i++) begin
            if (!inflight) break;
            cycle();
        end
        cycle();
        chk("drain_idle", 8'(s_busy), 8'h00);
    endtask

    initial begin
        int n;
        logic [1:0] v0;
        logic [7:0] d0;
        bit found;

        model_reset();
        #2;
        apply_reset();

        // Single op: 5 + 3 on requester 0.
        req_valid = 2'b01; req_opa = 16'h0005; req_opb = 16'h0003; req_opcode = 6'o00;
        rsp_ready = 2'b01;
        cycle();
        chk("r031_accept", 8'(s_ready), 8'h01);
        req_valid = 2'b00;
        cycle(); cycle(); cycle();
        chk("r031_rsp_valid", 8'(s_rsp_valid), 8'h01);
        chk("r031_rsp_data", s_rsp_data, 8'd8);
        cycle();
        chk("r031_busy_after", 8'(s_busy), 8'h00);

        // Tie right after reset: requester 0 first, then requester 1 (9 - 4).
        apply_reset();
        req_valid = 2'b11; req_opa = {8'd9, 8'd20}; req_opb = {8'd4, 8'd6};
        req_opcode = {3'b001, 3'b000}; rsp_ready = 2'b11;
        cycle();
        chk("r032_first_grant", 8'(s_ready), 8'h01);
        req_valid = 2'b10;
        cycle(); cycle(); cycle();
        chk("r032_rsp0_valid", 8'(s_rsp_valid), 8'h01);
        chk("r032_rsp0_data", s_rsp_data, 8'd26);
        cycle();
        chk("r032_second_grant", 8'(s_ready), 8'h02);
        req_valid = 2'b00;
        cycle(); cycle(); cycle();
        chk("r032_rsp1_valid", 8'(s_rsp_valid), 8'h02);
        chk("r032_rsp1_data", s_rsp_data, 8'd5);

        // Continuous contention: grants must alternate 0,1,0,1,...
        n = 0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 100 && n < 8; i++) begin
            req_opa = 16'($urandom); req_opb = 16'($urandom); req_opcode = 6'($urandom);
            cycle();
            if (s_ready != 2'b00) begin
                chk("r033_grant", 8'(s_ready), (n % 2 == 1) ? 8'h02 : 8'h01);
                n++;
            end
        end
        chk("r033_count", 8'(n), 8'd8);
        drain();

        // Backpressure: 5 RESP cycles without a valid rsp_ready.
        req_valid = 2'b01; req_opa = 16'h0033; req_opb = 16'h0011; req_opcode = 6'o05;
        rsp_ready = 2'b00;
        cycle();
        req_valid = 2'b11;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_rsp_valid != 2'b00) begin found = 1'b1; break; end
        end
        chk("r034_rsp_seen", 8'(found), 8'h01);
        v0 = s_rsp_valid;
        d0 = s_rsp_data;
        chk("r034_valid", 8'(v0), 8'h01);
        chk("r034_data", d0, 8'h22);
        for (int k = 1; k < 5; k++) begin
            rsp_ready = (k % 2 == 1) ? 2'b10 : 2'b00;
            cycle();
            chk("r034_hold_valid", 8'(s_rsp_valid), 8'(v0));
            chk("r034_hold_data", s_rsp_data, d0);
            chk("r034_no_ready", 8'(s_ready), 8'h00);
        end
        rsp_ready = 2'b01;
        req_valid = 2'b00;
        cycle();
        chk("r034_hs_valid", 8'(s_rsp_valid), 8'h01);
        cycle();
        chk("r034_after_valid", 8'(s_rsp_valid), 8'h00);
        chk("r034_after_busy", 8'(s_busy), 8'h00);

        // Truncated ALU result passes through unchanged: 16 * 16 -> 0x00.
        req_valid = 2'b01; req_opa = 16'h0010; req_opb = 16'h0010; req_opcode = 6'o02;
        rsp_ready = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle(); cycle(); cycle();
        chk("r035_valid", 8'(s_rsp_valid), 8'h01);
        chk("r035_data", s_rsp_data, 8'h00);
        drain();

        // Reset in EXEC abandons the transaction.
        req_valid = 2'b10; req_opa = 16'hAB00; req_opb = 16'hCD00; req_opcode = 6'o70;
        rsp_ready = 2'b11;
        cycle();
        chk("r036_accept", 8'(s_ready), 8'h02);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("r036_no_stale", 8'(s_rsp_valid), 8'h00);
        end
        req_valid = 2'b01; req_opa = 16'h0007; req_opb = 16'h0002; req_opcode = 6'o01;
        cycle();
        req_valid = 2'b00;
        cycle(); cycle(); cycle();
        chk("r036_fresh_valid", 8'(s_rsp_valid), 8'h01);
        chk("r036_fresh_data", s_rsp_data, 8'd5);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_opa    = 16'($urandom);
            req_opb    = 16'($urandom);
            req_opcode = 6'($urandom);
            rsp_ready  = 2'($urandom_range(0, 3));
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
